// File: rtl/gb_oam_dma_arbiter.sv
// OAM DMA engine ($FF46) and CPU/DMA arbiter for the shared system memory bus.
// Define GB_OAM_DMA_BUS_CONFLICT_EN to return the last DMA byte on blocked CPU reads.
module gb_oam_dma_arbiter #(
    parameter int unsigned TicksPerByte = 4,
    parameter int unsigned StartDelay   = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ClkEn,
    input  logic        CpuAccess,
    input  logic        CpuWrite,
    input  logic [15:0] CpuAddress,
    input  logic [7:0]  CpuDToTarget,
    output logic [7:0]  CpuDToInitiator,
    output logic        CpuReady,
    output logic        CpuDataReady,
    output logic        BusAccess,
    output logic        BusWrite,
    output logic [15:0] BusAddress,
    output logic [7:0]  BusDToTarget,
    input  logic [7:0]  BusDToInitiator,
    input  logic        BusReady,
    input  logic        BusDataReady,
    output logic        OamWrite,
    output logic [7:0]  OamAddress,
    output logic [7:0]  OamData,
    output logic        DmaActive
);

    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_READ, S_WRITE, S_WAIT} state_t;

    localparam logic [4:0] SlotTicks  = 5'(TicksPerByte);
    localparam logic [8:0] DelaySlots = 9'(StartDelay);

    state_t      state_q;
    logic [7:0]  src_q;
    logic [7:0]  index_q;
    logic [7:0]  dslot_q;
    logic [3:0]  cnt_q;
    logic        DmaActive_q;
    logic        OamWrite_q;
    logic [7:0]  OamAddress_q;
    logic [7:0]  OamData_q;

    logic        cpu_hi;
    logic        trigger;
    logic        slot_done;
    logic        delay_done;
    logic [3:0]  cnt_sat;
    logic [7:0]  src_eff;
    logic [7:0]  blocked_data;

    always_comb begin
        cpu_hi     = (CpuAddress[15:8] == 8'hFF);
        // A $FF46 write only counts when it actually reaches the bus, never while DMA owns it
        trigger    = ClkEn && CpuAccess && CpuWrite && BusReady &&
                     (CpuAddress == 16'hFF46) && (state_q != S_READ);
        slot_done  = (({1'b0, cnt_q} + 5'd1) >= SlotTicks);
        delay_done = (({1'b0, dslot_q} + 9'd1) >= DelaySlots);
        cnt_sat    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        src_eff    = (src_q > 8'hDF) ? (src_q & 8'hDF) : src_q;
    end

`ifdef GB_OAM_DMA_BUS_CONFLICT_EN
    assign blocked_data = OamData_q;
`else
    assign blocked_data = 8'hFF;
`endif

    always_ff @(posedge Clk) begin
        OamWrite_q <= 1'b0;
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            index_q      <= '0;
            dslot_q      <= '0;
            cnt_q        <= '0;
            DmaActive_q  <= 1'b0;
            OamAddress_q <= '0;
            OamData_q    <= '0;
        end else if (ClkEn) begin
            if (trigger) begin
                src_q       <= CpuDToTarget;
                index_q     <= '0;
                dslot_q     <= '0;
                cnt_q       <= '0;
                DmaActive_q <= 1'b1;
                state_q     <= (StartDelay == 0) ? S_READ : S_DELAY;
            end else begin
                unique case (state_q)
                    S_IDLE: ;
                    S_DELAY: begin
                        if (slot_done) begin
                            cnt_q <= '0;
                            if (delay_done) state_q <= S_READ;
                            else            dslot_q <= dslot_q + 8'd1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    S_READ: begin
                        cnt_q <= cnt_sat;
                        if (BusDataReady) begin
                            OamData_q    <= BusDToInitiator;
                            OamAddress_q <= index_q;
                            OamWrite_q   <= 1'b1;
                            state_q      <= S_WRITE;
                        end
                    end
                    // A stretched read may already have used up the slot, so WRITE can end it too
                    S_WRITE, S_WAIT: begin
                        if (slot_done) begin
                            cnt_q <= '0;
                            if (index_q == 8'h9F) begin
                                state_q     <= S_IDLE;
                                DmaActive_q <= 1'b0;
                            end else begin
                                index_q <= index_q + 8'd1;
                                state_q <= S_READ;
                            end
                        end else begin
                            cnt_q   <= cnt_sat;
                            state_q <= S_WAIT;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        BusAccess       = 1'b0;
        BusWrite        = 1'b0;
        BusAddress      = '0;
        BusDToTarget    = '0;
        CpuReady        = 1'b0;
        CpuDataReady    = 1'b0;
        CpuDToInitiator = '0;
        if (state_q == S_READ) begin
            BusAccess  = 1'b1;
            BusAddress = {src_eff, index_q};
            if (!cpu_hi) begin
                CpuReady        = CpuAccess;
                CpuDataReady    = CpuAccess;
                CpuDToInitiator = blocked_data;
            end
        end else if (!DmaActive_q || cpu_hi) begin
            BusAccess       = CpuAccess;
            BusWrite        = CpuWrite;
            BusAddress      = CpuAddress;
            BusDToTarget    = CpuDToTarget;
            CpuReady        = BusReady;
            CpuDataReady    = BusDataReady;
            CpuDToInitiator = BusDToInitiator;
        end else begin
            CpuReady        = CpuAccess;
            CpuDataReady    = CpuAccess;
            CpuDToInitiator = blocked_data;
        end
    end

    assign OamWrite   = OamWrite_q;
    assign OamAddress = OamAddress_q;
    assign OamData    = OamData_q;
    assign DmaActive  = DmaActive_q;

endmodule

// File: tb/tb_gb_oam_dma_arbiter.sv
// Self-checking bench for gb_oam_dma_arbiter: behavioural bus memory, OAM/bus monitors, scenario tasks.
module tb_gb_oam_dma_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ClkEn = 1'b0;
    logic        CpuAccess = 1'b0;
    logic        CpuWrite = 1'b0;
    logic [15:0] CpuAddress = '0;
    logic [7:0]  CpuDToTarget = '0;
    logic [7:0]  CpuDToInitiator;
    logic        CpuReady, CpuDataReady;
    logic        BusAccess, BusWrite;
    logic [15:0] BusAddress;
    logic [7:0]  BusDToTarget, BusDToInitiator;
    logic        BusReady, BusDataReady;
    logic        OamWrite, DmaActive;
    logic [7:0]  OamAddress, OamData;

    int tests = 0;
    int fails = 0;

    gb_oam_dma_arbiter #(.TicksPerByte(4), .StartDelay(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ClkEn(ClkEn),
        .CpuAccess(CpuAccess), .CpuWrite(CpuWrite), .CpuAddress(CpuAddress),
        .CpuDToTarget(CpuDToTarget), .CpuDToInitiator(CpuDToInitiator),
        .CpuReady(CpuReady), .CpuDataReady(CpuDataReady),
        .BusAccess(BusAccess), .BusWrite(BusWrite), .BusAddress(BusAddress),
        .BusDToTarget(BusDToTarget), .BusDToInitiator(BusDToInitiator),
        .BusReady(BusReady), .BusDataReady(BusDataReady),
        .OamWrite(OamWrite), .OamAddress(OamAddress), .OamData(OamData),
        .DmaActive(DmaActive)
    );

    always #5 Clk = ~Clk;

    // Clock-enable pattern: every cycle, or roughly 3 of 4 cycles when clken_rand is set
    bit clken_rand = 1'b0;
    always @(posedge Clk) begin
        #1;
        ClkEn = clken_rand ? ($urandom_range(3) != 0) : 1'b1;
    end

    // Memory behind the bus: a fixed pattern overlaid with whatever has been written
    logic [7:0]  seed = 8'h00;
    bit          wr_v [0:65535];
    logic [7:0]  wr_d [0:65535];
    int          bus_wr_cnt = 0;
    bit          stall_on = 1'b0;
    logic [15:0] stall_addr = 16'hFFFF;
    int          stall_seen = 0;
    int          stall_base = 0;
    logic        stalled;

    function automatic logic [7:0] pattern(input logic [15:0] a);
        if (a[15:8] == 8'hC1) return a[7:0] ^ 8'h5A;
        return (a[7:0] * 8'd37) ^ a[15:8] ^ seed;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return wr_v[a] ? wr_d[a] : pattern(a);
    endfunction

    assign stalled         = stall_on && (BusAddress == stall_addr) && ((stall_seen - stall_base) < 6);
    assign BusReady        = BusAccess;
    assign BusDataReady    = BusAccess && !BusWrite && !stalled;
    assign BusDToInitiator = (BusAccess && !BusWrite) ? mem_rd(BusAddress) : 8'h00;

    always @(posedge Clk) begin
        if (ClkEn && BusAccess && BusWrite && BusReady) begin
            wr_v[BusAddress] <= 1'b1;
            wr_d[BusAddress] <= BusDToTarget;
            bus_wr_cnt       <= bus_wr_cnt + 1;
        end
        if (ClkEn && BusAccess && !BusWrite && stalled) stall_seen <= stall_seen + 1;
    end

    // Monitors: OAM writes, DMA-side bus reads, DmaActive ticks and falling edges
    logic [15:0] oam_q [$];
    logic [15:0] rd_q [$];
    int active_ticks = 0;
    int falls = 0;
    logic prev_act = 1'b0;
    always @(negedge Clk) begin
        if (OamWrite) oam_q.push_back({OamAddress, OamData});
        if (ClkEn && BusAccess && !BusWrite && BusDataReady && !CpuAccess) rd_q.push_back(BusAddress);
        if (ClkEn && DmaActive) active_ticks = active_ticks + 1;
        if (prev_act && !DmaActive) falls = falls + 1;
        prev_act = DmaActive;
    end

    function automatic logic [15:0] exp_entry(input logic [7:0] src, input int i);
        logic [7:0] eff;
        eff = (src >= 8'hE0) ? src - 8'h20 : src;
        return {8'(i), mem_rd({eff, 8'(i)})};
    endfunction

    function automatic logic [15:0] got_entry(input int idx);
        if (idx < oam_q.size()) return oam_q[idx];
        return 16'hxxxx;
    endfunction

    task automatic cpu_xfer(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output logic drdy, output int lat);
        bit done;
        done = 1'b0; lat = 0; rd = '0; drdy = 1'b0;
        CpuAccess = 1'b1; CpuWrite = wr; CpuAddress = a; CpuDToTarget = wd;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge Clk);
            if (ClkEn && CpuReady) begin
                rd = CpuDToInitiator; drdy = CpuDataReady; done = 1'b1;
            end else begin
                lat++;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL cpu_timeout addr=%h: no CpuReady within 64 cycles, required CpuReady=1", a);
        end
        @(posedge Clk); #1;
        CpuAccess = 1'b0; CpuWrite = 1'b0;
    endtask

    task automatic wait_oam(input int n);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(posedge Clk); #1;
            if (oam_q.size() >= n) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL wait_oam: got %0d OAM writes, required %0d", oam_q.size(), n);
        end
    endtask

    task automatic wait_dma_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge Clk);
            if (!DmaActive) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL wait_dma_done: DmaActive still 1, required 0 within 6000 cycles");
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        tests++;
        if ({DmaActive, OamWrite, BusAccess, BusWrite, CpuReady, CpuDataReady} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl got=%b required=000000", {DmaActive, OamWrite, BusAccess, BusWrite, CpuReady, CpuDataReady});
        end
        tests++;
        if ({OamAddress, OamData, CpuDToInitiator} !== 24'h0) begin
            fails++;
            $display("FAIL reset_data got=%h required=000000", {OamAddress, OamData, CpuDToInitiator});
        end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_passthrough();
        logic [7:0] rd; logic drdy; int lat;
        cpu_xfer(1'b1, 16'hC020, 8'h77, rd, drdy, lat);
        tests++;
        if (wr_d[16'hC020] !== 8'h77) begin
            fails++; $display("FAIL pass_write got=%h required=77", wr_d[16'hC020]);
        end
        cpu_xfer(1'b0, 16'hC020, 8'h00, rd, drdy, lat);
        tests++;
        if ({drdy, rd} !== {1'b1, 8'h77}) begin
            fails++; $display("FAIL pass_read got=%b/%h required=1/77", drdy, rd);
        end
    endtask

    task automatic test_full_transfer();
        logic [7:0] rd; logic drdy; int lat; int base; int t0;
        clken_rand = 1'b1;
        base = oam_q.size(); t0 = active_ticks;
        cpu_xfer(1'b1, 16'hFF46, 8'hC1, rd, drdy, lat);
        wait_dma_done();
        tests++;
        if (oam_q.size() - base != 160) begin
            fails++; $display("FAIL full_count got=%0d required=160", oam_q.size() - base);
        end
        for (int i = 0; i < 160; i++) begin
            tests++;
            if (got_entry(base + i) !== exp_entry(8'hC1, i)) begin
                fails++; $display("FAIL full_byte[%0d] got=%h required=%h", i, got_entry(base + i), exp_entry(8'hC1, i));
            end
        end
        tests++;
        if (active_ticks - t0 != 644) begin
            fails++; $display("FAIL full_active_ticks got=%0d required=644", active_ticks - t0);
        end
        cpu_xfer(1'b0, 16'hFF46, 8'h00, rd, drdy, lat);
        tests++;
        if (rd !== 8'hC1) begin
            fails++; $display("FAIL ff46_readback got=%h required=c1", rd);
        end
        clken_rand = 1'b0;
    endtask

    task automatic test_echo_source();
        logic [7:0] rd; logic drdy; int lat; int rbase; int base;
        clken_rand = 1'b1;
        seed = 8'($urandom);
        rbase = rd_q.size(); base = oam_q.size();
        cpu_xfer(1'b1, 16'hFF46, 8'hE2, rd, drdy, lat);
        wait_dma_done();
        tests++;
        if (rd_q.size() - rbase != 160) begin
            fails++; $display("FAIL echo_count got=%0d required=160", rd_q.size() - rbase);
        end
        for (int i = 0; i < 160; i++) begin
            logic [15:0] ga;
            ga = (rbase + i < rd_q.size()) ? rd_q[rbase + i] : 16'hxxxx;
            tests++;
            if (ga !== 16'hC200 + 16'(i)) begin
                fails++; $display("FAIL echo_addr[%0d] got=%h required=%h", i, ga, 16'hC200 + 16'(i));
            end
        end
        tests++;
        if (got_entry(base + 159) !== exp_entry(8'hE2, 159)) begin
            fails++; $display("FAIL echo_last_byte got=%h required=%h", got_entry(base + 159), exp_entry(8'hE2, 159));
        end
        clken_rand = 1'b0;
    endtask

    task automatic test_cpu_during_dma();
        logic [7:0] rd; logic drdy; int lat; int base; int wcnt; int stalls; logic [7:0] exp_blk;
        base = oam_q.size();
        cpu_xfer(1'b1, 16'hFF46, 8'hC1, rd, drdy, lat);
        wait_oam(base + 5);
`ifdef GB_OAM_DMA_BUS_CONFLICT_EN
        exp_blk = mem_rd(16'hC104);
`else
        exp_blk = 8'hFF;
`endif
        cpu_xfer(1'b0, 16'h8000, 8'h00, rd, drdy, lat);
        tests++;
        if ({lat == 0, drdy, rd} !== {1'b1, 1'b1, exp_blk}) begin
            fails++; $display("FAIL blocked_read lat=%0d drdy=%b data=%h required lat=0 drdy=1 data=%h", lat, drdy, rd, exp_blk);
        end
        wcnt = bus_wr_cnt;
        cpu_xfer(1'b1, 16'hC000, 8'h12, rd, drdy, lat);
        @(posedge Clk); #1;
        tests++;
        if (bus_wr_cnt != wcnt || lat != 0) begin
            fails++; $display("FAIL blocked_write bus_writes=%0d lat=%0d required 0 and 0", bus_wr_cnt - wcnt, lat);
        end
        stalls = 0;
        for (int j = 0; j < 10; j++) begin
            logic [15:0] a;
            a = 16'hFF80 + 16'(j);
            cpu_xfer(1'b0, a, 8'h00, rd, drdy, lat);
            if (lat > 0) stalls++;
            tests++;
            if ({drdy, rd} !== {1'b1, mem_rd(a)} || lat > 1) begin
                fails++; $display("FAIL hram_read[%h] drdy=%b data=%h lat=%0d required 1/%h lat<=1", a, drdy, rd, lat, mem_rd(a));
            end
        end
        tests++;
        if (stalls == 0 || stalls == 10) begin
            fails++; $display("FAIL hram_collisions got=%0d stalled reads, required between 1 and 9", stalls);
        end
        wait_dma_done();
        tests++;
        if (oam_q.size() - base != 160 || got_entry(base + 159) !== exp_entry(8'hC1, 159)) begin
            fails++; $display("FAIL cpu_dma_count got=%0d last=%h required 160/%h", oam_q.size() - base, got_entry(base + 159), exp_entry(8'hC1, 159));
        end
    endtask

    task automatic test_retrigger();
        logic [7:0] rd; logic drdy; int lat; int base; int f0;
        base = oam_q.size(); f0 = falls;
        cpu_xfer(1'b1, 16'hFF46, 8'hC1, rd, drdy, lat);
        wait_oam(base + 64);
        cpu_xfer(1'b1, 16'hFF46, 8'hD0, rd, drdy, lat);
        wait_dma_done();
        tests++;
        if (oam_q.size() - base != 224) begin
            fails++; $display("FAIL retrig_count got=%0d required=224", oam_q.size() - base);
        end
        for (int i = 0; i < 64; i++) begin
            tests++;
            if (got_entry(base + i) !== exp_entry(8'hC1, i)) begin
                fails++; $display("FAIL retrig_first[%0d] got=%h required=%h", i, got_entry(base + i), exp_entry(8'hC1, i));
            end
        end
        for (int i = 0; i < 160; i++) begin
            tests++;
            if (got_entry(base + 64 + i) !== exp_entry(8'hD0, i)) begin
                fails++; $display("FAIL retrig_second[%0d] got=%h required=%h", i, got_entry(base + 64 + i), exp_entry(8'hD0, i));
            end
        end
        tests++;
        if (falls - f0 != 1) begin
            fails++; $display("FAIL retrig_continuous got=%0d DmaActive falls, required 1", falls - f0);
        end
    endtask

    task automatic test_stretch();
        logic [7:0] rd; logic drdy; int lat; int base; int t0; int dt;
        base = oam_q.size(); t0 = active_ticks;
        stall_base = stall_seen; stall_addr = 16'hC110; stall_on = 1'b1;
        cpu_xfer(1'b1, 16'hFF46, 8'hC1, rd, drdy, lat);
        wait_dma_done();
        stall_on = 1'b0;
        tests++;
        if (oam_q.size() - base != 160) begin
            fails++; $display("FAIL stretch_count got=%0d required=160", oam_q.size() - base);
        end
        for (int i = 0; i < 160; i++) begin
            tests++;
            if (got_entry(base + i) !== exp_entry(8'hC1, i)) begin
                fails++; $display("FAIL stretch_byte[%0d] got=%h required=%h", i, got_entry(base + i), exp_entry(8'hC1, i));
            end
        end
        dt = active_ticks - t0;
        tests++;
        if (dt <= 644 || dt > 650) begin
            fails++; $display("FAIL stretch_ticks got=%0d required 645..650", dt);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd; logic drdy; int lat; int base;
        base = oam_q.size();
        cpu_xfer(1'b1, 16'hFF46, 8'hC1, rd, drdy, lat);
        wait_oam(base + 8'h50);
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        tests++;
        if ({DmaActive, OamWrite} !== 2'b00) begin
            fails++; $display("FAIL reset_mid_outputs got=%b required=00", {DmaActive, OamWrite});
        end
        repeat (40) @(posedge Clk);
        #1;
        tests++;
        if (oam_q.size() - base != 8'h50 || DmaActive !== 1'b0) begin
            fails++; $display("FAIL reset_mid_quiet writes=%0d active=%b required 80/0", oam_q.size() - base, DmaActive);
        end
        cpu_xfer(1'b0, 16'hC105, 8'h00, rd, drdy, lat);
        tests++;
        if ({lat == 0, drdy, rd} !== {1'b1, 1'b1, 8'h5F}) begin
            fails++; $display("FAIL reset_mid_pass lat=%0d drdy=%b data=%h required 0/1/5f", lat, drdy, rd);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_full_transfer();
        test_echo_source();
        test_cpu_during_dma();
        test_retrigger();
        test_stretch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
